// File: rtl/uart_rx_cfg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_cfg : oversampled UART receiver, runtime parity / stop config,   |
// |               3-sample majority vote, parity/framing/break reporting.    |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 sample_tick_i,
  input  logic                 rx_i,
  input  logic [1:0]           parity_mode_i,
  input  logic                 stop2_i,
  output logic                 rx_done_tick_o,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 break_o
);

  localparam int c_tick_w = $clog2(OVERSAMPLE);
  localparam int c_bit_w  = $clog2(DATA_BITS);
  localparam logic [c_tick_w-1:0] c_one  = c_tick_w'(1);
  localparam logic [c_tick_w-1:0] c_half = c_tick_w'(OVERSAMPLE / 2);
  localparam logic [c_tick_w-1:0] c_last = c_tick_w'(OVERSAMPLE - 1);
  localparam logic [c_bit_w-1:0]  c_last_bit = c_bit_w'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic                   rx_meta_q, rxs_q;
  logic [c_tick_w-1:0]    tick_q, tick_d;
  logic [c_bit_w-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   s0_q, s0_d, s1_q, s1_d;
  logic [1:0]             mode_q, mode_d;
  logic                   stop2_q, stop2_d;
  logic                   par_q, par_d;
  logic                   stop1_q, stop1_d;
  logic                   ferr_acc_q, ferr_acc_d;
  logic                   done_q, done_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   brk_q, brk_d;

  logic w_tick, w_vote_pt, w_end_pt, w_vote, w_par_en, w_last_stop, w_brk;

  // Ticks are only meaningful while a frame is in progress.
  assign w_tick      = sample_tick_i && (state_q != S_IDLE) && (state_q != S_BREAK);
  assign w_vote_pt   = w_tick && (tick_q == c_half + c_one);
  assign w_end_pt    = w_tick && (tick_q == c_last);
  assign w_vote      = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
  assign w_par_en    = (mode_q == 2'b01) || (mode_q == 2'b10);
  assign w_last_stop = !stop2_q || (bit_q != '0);
  assign w_brk       = (shift_q == '0) && (!w_par_en || !par_q) &&
                       ((bit_q == '0) ? !w_vote : !stop1_q);

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    mode_d     = mode_q;
    stop2_d    = stop2_q;
    par_d      = par_q;
    stop1_d    = stop1_q;
    ferr_acc_d = ferr_acc_q;
    done_d     = 1'b0;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;

    if (w_tick) begin
      tick_d = (tick_q == c_last) ? '0 : tick_q + c_one;
      if (tick_q == c_half - c_one) s0_d = rxs_q;
      if (tick_q == c_half)         s1_d = rxs_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          mode_d     = parity_mode_i;
          stop2_d    = stop2_i;
          tick_d     = '0;
          bit_d      = '0;
          ferr_acc_d = 1'b0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (w_vote_pt && w_vote) begin
          state_d = S_IDLE;
        end else if (w_end_pt) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (w_vote_pt) shift_d = {w_vote, shift_q[DATA_BITS-1:1]};
        if (w_end_pt) begin
          if (bit_q == c_last_bit) begin
            bit_d   = '0;
            state_d = w_par_en ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + c_bit_w'(1);
          end
        end
      end
      S_PARITY: begin
        if (w_vote_pt) par_d = w_vote;
        if (w_end_pt) begin
          bit_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (w_vote_pt) begin
          if (bit_q == '0) stop1_d = w_vote;
          if (w_last_stop) begin
            // Complete at mid-bit so a following start edge is never missed.
            done_d  = 1'b1;
            data_d  = w_brk ? '0 : shift_q;
            perr_d  = w_par_en && ((^shift_q ^ par_q) != (mode_q == 2'b10));
            ferr_d  = ferr_acc_q | !w_vote;
            brk_d   = w_brk;
            state_d = w_brk ? S_BREAK : S_IDLE;
          end else begin
            ferr_acc_d = ferr_acc_q | !w_vote;
          end
        end else if (w_end_pt) begin
          bit_d = c_bit_w'(1);
        end
      end
      S_BREAK: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      state_q    <= S_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      mode_q     <= 2'b00;
      stop2_q    <= 1'b0;
      par_q      <= 1'b0;
      stop1_q    <= 1'b0;
      ferr_acc_q <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      rx_meta_q  <= rx_i;
      rxs_q      <= rx_meta_q;
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      mode_q     <= mode_d;
      stop2_q    <= stop2_d;
      par_q      <= par_d;
      stop1_q    <= stop1_d;
      ferr_acc_q <= ferr_acc_d;
      done_q     <= done_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
    end
  end

  assign rx_done_tick_o = done_q;
  assign rx_data_o      = data_q;
  assign parity_err_o   = perr_q;
  assign frame_err_o    = ferr_q;
  assign break_o        = brk_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_rx_cfg : directed scoreboard bench for uart_rx_cfg.              |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_uart_rx_cfg;

  localparam int DB = 8;
  localparam int OS = 16;
  localparam int H  = OS / 2;

  typedef struct packed {
    logic [DB-1:0] data;
    logic          perr;
    logic          ferr;
    logic          brk;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_tick = 1'b0;
  logic          rx = 1'b1;
  logic [1:0]    parity_mode = 2'b00;
  logic          stop2 = 1'b0;
  logic          rx_done;
  logic [DB-1:0] rx_data;
  logic          perr, ferr, brk;

  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  int   tick_total = 0;
  int   edge_tick = 0;
  int   last_done_tick = 0;
  logic prev_done = 1'b0;
  exp_t exp_q[$];

  uart_rx_cfg #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .sample_tick_i  (sample_tick),
    .rx_i           (rx),
    .parity_mode_i  (parity_mode),
    .stop2_i        (stop2),
    .rx_done_tick_o (rx_done),
    .rx_data_o      (rx_data),
    .parity_err_o   (perr),
    .frame_err_o    (ferr),
    .break_o        (brk)
  );

  always #5 clk = ~clk;

  // One sample tick every 4 clocks, changed on the falling edge.
  initial begin
    forever begin
      repeat (3) @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
    end
  end

  always @(posedge clk) if (sample_tick) tick_total++;

  // Scoreboard: every done pulse pops one expected frame.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) begin
        checks++;
        assert (rx_done === 1'b0) else begin
          errors++; $error("FAIL done_width: got %b want 0", rx_done);
        end
      end
      if (rx_done === 1'b1) begin
        exp_t e;
        done_cnt++;
        last_done_tick = tick_total;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++; $error("FAIL unexpected_done: got data=%0h queued=0 want queued>0", rx_data);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checks++;
          assert (rx_data === e.data) else begin
            errors++; $error("FAIL data: got %0h want %0h", rx_data, e.data);
          end
          checks++;
          assert (perr === e.perr) else begin
            errors++; $error("FAIL parity_err: got %b want %b", perr, e.perr);
          end
          checks++;
          assert (ferr === e.ferr) else begin
            errors++; $error("FAIL frame_err: got %b want %b", ferr, e.ferr);
          end
          checks++;
          assert (brk === e.brk) else begin
            errors++; $error("FAIL break: got %b want %b", brk, e.brk);
          end
        end
      end
      prev_done = rx_done;
    end
  end

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (sample_tick) k++;
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    @(negedge clk);
    rx = v;
    wait_ticks(n);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic [1:0] pm, input logic s2,
                            input logic flip_par, input logic [1:0] stop_v, input int glitch_bit);
    logic pen, pbit;
    exp_t e;
    pen  = (pm == 2'b01) || (pm == 2'b10);
    pbit = (pm == 2'b10) ? ~(^d) : (^d);
    if (flip_par) pbit = ~pbit;
    e.brk  = (d == '0) && (!pen || !pbit) && !stop_v[0];
    e.data = e.brk ? '0 : d;
    e.perr = pen && flip_par;
    e.ferr = !stop_v[0] || (s2 && !stop_v[1]);
    exp_q.push_back(e);
    parity_mode = pm;
    stop2 = s2;
    wait_ticks(1);
    @(negedge clk);
    rx = 1'b0;
    edge_tick = tick_total;
    wait_ticks(OS);
    // Mode changes after the start bit must not affect this frame.
    parity_mode = pm ^ 2'b11;
    stop2 = ~s2;
    for (int i = 0; i < DB; i++) begin
      if (i == glitch_bit) begin
        drive_bit(d[i], H);
        drive_bit(1'b0, 1);
        drive_bit(d[i], OS - H - 1);
      end else begin
        drive_bit(d[i], OS);
      end
    end
    if (pen) drive_bit(pbit, OS);
    drive_bit(stop_v[0], OS);
    if (s2) drive_bit(stop_v[1], OS);
    drive_bit(1'b1, OS);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++; $error("FAIL %s_drain: got pending=%0d want 0", tag, exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    assert (rx_done === 1'b0) else begin errors++; $error("FAIL %s_done: got %b want 0", tag, rx_done); end
    checks++;
    assert (rx_data === '0) else begin errors++; $error("FAIL %s_data: got %0h want 0", tag, rx_data); end
    checks++;
    assert (perr === 1'b0) else begin errors++; $error("FAIL %s_perr: got %b want 0", tag, perr); end
    checks++;
    assert (ferr === 1'b0) else begin errors++; $error("FAIL %s_ferr: got %b want 0", tag, ferr); end
    checks++;
    assert (brk === 1'b0) else begin errors++; $error("FAIL %s_brk: got %b want 0", tag, brk); end
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    wait_ticks(4);

    // 8N1 0xA5 plus completion latency
    send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 2'b11, -1);
    wait_drain("a5");
    checks++;
    assert (last_done_tick - edge_tick - 1 === 9 * OS + 9) else begin
      errors++; $error("FAIL latency: got %0d want %0d", last_done_tick - edge_tick - 1, 9 * OS + 9);
    end

    // Even parity, good then bad parity bit
    send_frame(8'h07, 2'b01, 1'b0, 1'b0, 2'b11, -1);
    send_frame(8'h07, 2'b01, 1'b0, 1'b1, 2'b11, -1);
    // Odd parity with correct bit
    send_frame(8'h3A, 2'b10, 1'b0, 1'b0, 2'b11, -1);
    wait_drain("parity");

    // Two stop bits, second low, then a clean frame
    send_frame(8'h96, 2'b00, 1'b1, 1'b0, 2'b01, -1);
    send_frame(8'h3C, 2'b00, 1'b1, 1'b0, 2'b11, -1);
    wait_drain("stop2");

    // Start glitch of 4 ticks is rejected
    base = done_cnt;
    wait_ticks(1);
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 3 * OS);
    checks++;
    assert (done_cnt === base) else begin
      errors++; $error("FAIL start_glitch: got dones=%0d want %0d", done_cnt - base, 0);
    end
    // Single-tick spike inside data bit 2
    send_frame(8'hFF, 2'b00, 1'b0, 1'b0, 2'b11, 2);
    wait_drain("spike");

    // Long break: exactly one done, no retrigger until line returns high
    base = done_cnt;
    exp_q.push_back('{data: '0, perr: 1'b0, ferr: 1'b1, brk: 1'b1});
    parity_mode = 2'b00;
    stop2 = 1'b0;
    wait_ticks(1);
    drive_bit(1'b0, 30 * OS);
    checks++;
    assert (done_cnt === base + 1) else begin
      errors++; $error("FAIL break_count: got %0d want %0d", done_cnt - base, 1);
    end
    drive_bit(1'b1, 2 * OS);
    checks++;
    assert (done_cnt === base + 1) else begin
      errors++; $error("FAIL break_release: got %0d want %0d", done_cnt - base, 1);
    end
    send_frame(8'h55, 2'b00, 1'b0, 1'b0, 2'b11, -1);
    wait_drain("break");

    // Reset in the middle of 0x81
    base = done_cnt;
    wait_ticks(1);
    drive_bit(1'b0, OS);
    drive_bit(1'b1, OS);
    drive_bit(1'b0, OS);
    drive_bit(1'b0, OS);
    drive_bit(1'b0, H);
    @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    wait_ticks(3 * OS);
    checks++;
    assert (done_cnt === base) else begin
      errors++; $error("FAIL reset_no_done: got %0d want %0d", done_cnt - base, 0);
    end
    send_frame(8'h81, 2'b00, 1'b0, 1'b0, 2'b11, -1);
    wait_drain("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
